async_event_arbiter: RTL and testbench
======================================

Name: async_event_arbiter

Overview:
- Multi-channel front end for asynchronous event inputs, such as pushbuttons or foreign-clock strobes.
- Each channel has its own synchronizer and rising-edge detector. A detected edge is latched as a pending event.
- Pending events are shared onto a single valid/ready event port with round-robin arbitration, and the port reports the channel ID.
- The block sits between raw async inputs and downstream control FSMs. Overruns are flagged.

Parameters:
- N_CH, 4, number of async input channels (2..16).
- SYNC_STAGES, 2, flip-flops in each channel's synchronizer chain (>=2).
- Derived localparam: CH_W = max(1, clog2(N_CH)).

Ports:
- outclk  in  1  system clock; all flops are rising-edge triggered.
- reset_n  in  1  asynchronous active-low reset.
- async_sig  in  N_CH  raw asynchronous inputs, one per channel.
- enable  in  N_CH  per-channel enable mask, synchronous to outclk.
- evt_valid  out  1  an event is offered on evt_ch.
- evt_ready  in  1  consumer accepts the offered event.
- evt_ch  out  CH_W  channel index of the offered event.
- pending  out  N_CH  latched, not-yet-offered events (status).
- evt_overrun  out  1  sticky flag: a channel edge was lost.
- overrun_clr  in  1  synchronous clear of evt_overrun.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately even mid-handshake):
  - sync chains=0, prev flops=0, pending=0.
  - evt_valid=0, evt_ch=0, evt_overrun=0, last_grant=N_CH-1, state=IDLE.
- Per-channel edge detection:
  - s[0] samples async_sig; s[SYNC_STAGES-1] is the synced level.
  - prev<=synced each cycle; rise = synced & ~prev.
  - A level held high produces exactly one rise.
  - A level already high at reset release counts as one rise.
- Latency: an async_sig rise meeting setup before edge k sets pending at edge k+SYNC_STAGES. Earliest evt_valid=1 is after edge k+SYNC_STAGES+1.
- Pending update, per channel, each edge, in priority order:
  - enable=0: pending<=0 and rise is ignored; no overrun.
  - rise & pending already 1 & not being granted this cycle: pending stays 1 and evt_overrun<=1.
  - rise: pending<=1. This includes the cycle in which the channel is granted; the new event survives with no overrun.
  - granted this cycle: pending<=0.
- evt_overrun: sticky. overrun_clr=1 clears it; a simultaneous new overrun wins (stays 1).
- FSM, two states:
  - IDLE:
    - Condition: evt_valid=0.
    - If any (pending & enable), grant the first set channel searching last_grant+1, last_grant+2, ... with wrap modulo N_CH.
    - On a grant, at the same edge: evt_ch<=granted index, evt_valid<=1, pending bit cleared, go to OFFER.
  - OFFER:
    - evt_valid=1; evt_ch held stable while evt_ready=0.
    - On an edge with evt_valid&evt_ready: last_grant<=evt_ch, evt_valid<=0, go to IDLE.
- Throughput: at most one event per 2 cycles, with a mandatory 1-cycle valid gap.
- enable dropping during OFFER does not retract the current offer.
- evt_valid must not depend combinationally on evt_ready.
- With N_CH not a power of two, indices >= N_CH are never granted.

Test Plan (N_CH=4, SYNC_STAGES=2, outclk period 4):
- Single event: reset, enable=4'hF, evt_ready=1, async_sig[2] rises 1 time unit before edge k and stays high -> pending[2]=1 after edge k+2; evt_valid=1, evt_ch=2 after k+3 for exactly one cycle; no further events.
- Round robin: async_sig 4'h0->4'hF at one time, evt_ready=1 -> evt_ch sequence 0,1,2,3 on alternating cycles; then repeat with last_grant=1 and channels 0 and 3 rising together -> order 3,0.
- Backpressure: evt_ready=0 for 10 cycles during an offer on ch1 -> evt_valid=1 and evt_ch=1 stable throughout; evt_ready=1 -> handshake at the next edge, evt_valid=0 the cycle after.
- Overrun: evt_ready=0, three separated rises on ch1 -> first is offered, second sets pending[1], third sets evt_overrun=1; pulse overrun_clr -> evt_overrun=0, pending[1] still 1.
- Masking, plus async square wave on ch0 (7 high / 7 low): enable=4'b0111 with ch3 toggling -> pending[3]=0, ch3 never offered. Ch0 with evt_ready=1 over 140 time units -> exactly 10 events with evt_ch=0.
- Reset mid-OFFER: drive reset_n=0 between edges while evt_valid=1 -> evt_valid=0, pending=0, evt_overrun=0 immediately; after release, the first grant goes to channel 0 when all channels are pending.

Source files
------------

// File: rtl/async_event_arbiter.sv
// async_event_arbiter: synchronizes N_CH asynchronous inputs, detects rising
// edges, latches them as pending events and offers them one at a time on a
// valid/ready port in round-robin order. Lost edges raise a sticky overrun.
`timescale 1ns/1ps

module async_event_arbiter #(
   parameter int  N_CH        = 4,
   parameter int  SYNC_STAGES = 2,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            outclk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] async_sig,
   input  logic [N_CH-1:0] enable,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CH_W-1:0] evt_ch,
   output logic [N_CH-1:0] pending,
   output logic            evt_overrun,
   input  logic            overrun_clr
);

   // Two-state handshake FSM; evt_valid is high exactly while in OFFER.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] prev_q;
   logic [N_CH-1:0] pending_q,    pending_d;
   logic            valid_q,      valid_d;
   logic [CH_W-1:0] ch_q,         ch_d;
   logic [CH_W-1:0] last_grant_q, last_grant_d;
   logic            overrun_q,    overrun_d;
   logic [0:0]      state_q,      state_d;

   logic [N_CH-1:0] synced_s;
   logic [N_CH-1:0] rise_s;
   logic [N_CH-1:0] req_s;
   logic [N_CH-1:0] grant_s;
   logic            grant_found_s;
   logic [CH_W-1:0] grant_idx_s;
   logic            new_overrun_s;

   assign synced_s = sync_q[SYNC_STAGES-1];
   assign rise_s   = synced_s & ~prev_q;
   assign req_s    = pending_q & enable;

   // Synchronizer chains and previous-level flops for edge detection.
   always_ff @(posedge outclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= async_sig;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= synced_s;
      end
   end

   // Round-robin search: first requesting channel after last_grant, wrapping.
   always_comb begin
      int          idx_v;
      logic [CH_W-1:0] cand_v;
      idx_v         = 0;
      cand_v        = '0;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int off = 1; off <= N_CH; off++) begin
         idx_v = int'(last_grant_q) + off;
         if (idx_v >= N_CH) begin
            idx_v = idx_v - N_CH;
         end else begin
            idx_v = idx_v;
         end
         cand_v = CH_W'(idx_v);
         if (!grant_found_s && req_s[cand_v]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_v;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Handshake FSM: grant in IDLE, hold the offer in OFFER until accepted.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      ch_d         = ch_q;
      last_grant_d = last_grant_q;
      grant_s      = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_found_s) begin
               state_d = ST_OFFER;
               valid_d = 1'b1;
               ch_d    = grant_idx_s;
               grant_s = {{(N_CH-1){1'b0}}, 1'b1} << grant_idx_s;
            end else begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         ST_OFFER: begin
            if (evt_ready) begin
               last_grant_d = ch_q;
               valid_d      = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               valid_d = 1'b1;
               state_d = ST_OFFER;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Pending latch per channel: mask, overrun, new rise, then grant clear.
   always_comb begin
      pending_d     = pending_q;
      new_overrun_s = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!enable[i]) begin
            pending_d[i] = 1'b0;
         end else if (rise_s[i] && pending_q[i] && !grant_s[i]) begin
            pending_d[i]  = 1'b1;
            new_overrun_s = 1'b1;
         end else if (rise_s[i]) begin
            pending_d[i] = 1'b1;
         end else if (grant_s[i]) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_q[i];
         end
      end
      overrun_d = new_overrun_s | (overrun_q & ~overrun_clr);
   end

   // State, offer and status registers.
   always_ff @(posedge outclk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q    <= '0;
         valid_q      <= 1'b0;
         ch_q         <= '0;
         last_grant_q <= CH_W'(N_CH-1);
         overrun_q    <= 1'b0;
         state_q      <= ST_IDLE;
      end else begin
         pending_q    <= pending_d;
         valid_q      <= valid_d;
         ch_q         <= ch_d;
         last_grant_q <= last_grant_d;
         overrun_q    <= overrun_d;
         state_q      <= state_d;
      end
   end

   assign evt_valid   = valid_q;
   assign evt_ch      = ch_q;
   assign pending     = pending_q;
   assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_async_event_arbiter.sv
// Scoreboard bench for async_event_arbiter: stimulus pushes expected channel
// IDs, a negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps

module tb_async_event_arbiter;

   logic       outclk;
   logic       reset_n;
   logic [3:0] async_sig;
   logic [3:0] enable;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_ch;
   logic [3:0] pending;
   logic       evt_overrun;
   logic       overrun_clr;

   int tests = 0;
   int fails = 0;
   int sb[$];

   async_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
      .outclk      (outclk),
      .reset_n     (reset_n),
      .async_sig   (async_sig),
      .enable      (enable),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_ch      (evt_ch),
      .pending     (pending),
      .evt_overrun (evt_overrun),
      .overrun_clr (overrun_clr)
   );

   // Clock, period 4.
   initial begin
      outclk = 1'b0;
      forever #2 outclk = ~outclk;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every accepted event against the scoreboard and
   // enforce the idle cycle after each handshake.
   initial begin
      bit hs_prev;
      int exp;
      hs_prev = 1'b0;
      forever begin
         @(negedge outclk);
         if (!reset_n) begin
            hs_prev = 1'b0;
         end else begin
            if (hs_prev) check("valid_gap", int'(evt_valid), 0);
            if (evt_valid && evt_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_event: got ch %0d expected none (t=%0t)",
                           int'(evt_ch), $time);
               end else begin
                  exp = sb.pop_front();
                  check("evt_ch", int'(evt_ch), exp);
               end
               hs_prev = 1'b1;
            end else begin
               hs_prev = 1'b0;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge outclk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input int budget);
      int c;
      c = 0;
      while (!evt_valid && c < budget) begin
         cyc(1);
         c++;
      end
      if (!evt_valid) begin
         tests++;
         fails++;
         $display("FAIL wait_valid: got timeout expected evt_valid=1 (t=%0t)", $time);
      end
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while ((sb.size() != 0 || evt_valid) && c < budget) begin
         cyc(1);
         c++;
      end
      if (sb.size() != 0 || evt_valid) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d outstanding expected 0 (t=%0t)", sb.size(), $time);
         sb.delete();
      end
      cyc(4);
   endtask

   task automatic pulse(input logic [3:0] mask);
      async_sig = async_sig | mask;
      cyc(3);
      async_sig = async_sig & ~mask;
      cyc(4);
   endtask

   initial begin
      reset_n     = 1'b0;
      async_sig   = 4'h0;
      enable      = 4'hF;
      evt_ready   = 1'b1;
      overrun_clr = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      cyc(1);

      // Reset state
      check("rst_valid",   int'(evt_valid),   0);
      check("rst_ch",      int'(evt_ch),      0);
      check("rst_pending", int'(pending),     0);
      check("rst_overrun", int'(evt_overrun), 0);

      // Single event on ch2: rise 1 unit before edge k
      @(posedge outclk);
      #3;
      async_sig[2] = 1'b1;
      sb.push_back(2);
      @(posedge outclk);                 // edge k
      @(posedge outclk); #1;             // after k+1
      check("single_pend_k1", int'(pending[2]), 0);
      @(posedge outclk); #1;             // after k+2
      check("single_pend_k2", int'(pending[2]), 1);
      check("single_valid_k2", int'(evt_valid), 0);
      @(posedge outclk); #1;             // after k+3
      check("single_valid_k3", int'(evt_valid), 1);
      check("single_ch_k3",    int'(evt_ch),    2);
      check("single_pend_k3",  int'(pending),   0);
      cyc(1);
      check("single_valid_k4", int'(evt_valid), 0);
      drain(20);
      async_sig = 4'h0;
      cyc(4);

      // Round robin from reset: 0,1,2,3
      do_reset();
      async_sig = 4'hF;
      sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
      drain(40);
      async_sig = 4'h0;
      cyc(4);
      // last_grant=1, then ch0 and ch3 together: 3 then 0
      async_sig[1] = 1'b1;
      sb.push_back(1);
      drain(20);
      async_sig = async_sig | 4'b1001;
      sb.push_back(3); sb.push_back(0);
      drain(30);
      async_sig = 4'h0;
      cyc(4);

      // Backpressure on ch1
      evt_ready = 1'b0;
      async_sig[1] = 1'b1;
      sb.push_back(1);
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", int'(evt_valid), 1);
         check("bp_ch",    int'(evt_ch),    1);
         cyc(1);
      end
      evt_ready = 1'b1;
      cyc(1);
      check("bp_valid_after", int'(evt_valid), 0);
      drain(20);
      async_sig = 4'h0;
      cyc(4);

      // Overrun on ch1
      evt_ready = 1'b0;
      pulse(4'b0010);
      check("ov_first_valid", int'(evt_valid),   1);
      check("ov_first_ch",    int'(evt_ch),      1);
      check("ov_first_pend",  int'(pending[1]),  0);
      pulse(4'b0010);
      check("ov_second_pend", int'(pending[1]),  1);
      check("ov_second_flag", int'(evt_overrun), 0);
      pulse(4'b0010);
      check("ov_third_flag",  int'(evt_overrun), 1);
      check("ov_third_pend",  int'(pending[1]),  1);
      overrun_clr = 1'b1;
      cyc(1);
      overrun_clr = 1'b0;
      check("ov_clr_flag", int'(evt_overrun), 0);
      check("ov_clr_pend", int'(pending[1]),  1);
      sb.push_back(1); sb.push_back(1);
      evt_ready = 1'b1;
      drain(20);

      // Masking ch3 while ch0 runs a 7/7 square wave for 140 units
      enable    = 4'b0111;
      async_sig = 4'h0;
      for (int i = 0; i < 10; i++) sb.push_back(0);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               async_sig[0] = 1'b1;
               #7;
               async_sig[0] = 1'b0;
               #7;
            end
         end
         begin
            for (int i = 0; i < 14; i++) begin
               async_sig[3] = ~async_sig[3];
               #5;
            end
            async_sig[3] = 1'b0;
         end
         begin
            for (int i = 0; i < 35; i++) begin
               @(posedge outclk);
               #1;
               check("mask_pend3", int'(pending[3]), 0);
            end
         end
      join
      drain(20);
      check("mask_overrun", int'(evt_overrun), 0);
      enable = 4'hF;
      cyc(4);

      // Reset in the middle of an offer
      evt_ready = 1'b0;
      async_sig = 4'hF;
      wait_valid(20);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid",   int'(evt_valid),   0);
      check("mid_rst_pending", int'(pending),     0);
      check("mid_rst_overrun", int'(evt_overrun), 0);
      cyc(2);
      evt_ready = 1'b1;
      sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
      reset_n = 1'b1;
      drain(40);

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
